cdb_broadcast: RTL



---
 rtl/cdb_broadcast_if.sv | 35 +++
 rtl/cdb_broadcast.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast_if.sv
// Global configuration and the result/CDB bus bundle used by cdb_broadcast.
// master drives results and watches the CDB; slave is the broadcaster itself.
package global_config_pkg;
  typedef struct packed {
    int ILEN;
    int XLEN;
  } cfg_t;

  localparam cfg_t Cfg = '{ILEN: 32, XLEN: 32};
endpackage

interface cdb_broadcast_if #(
  parameter int NUM_SRC = 4,
  parameter int CDB_W   = 4,
  parameter int DATA_W  = global_config_pkg::Cfg.ILEN,
  parameter int TAG_W   = 6
);
  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] src_ready;
  logic [TAG_W-1:0]   src_tag [NUM_SRC];
  logic [DATA_W-1:0]  src_val [NUM_SRC];
  logic [CDB_W-1:0]   cdb_valid;
  logic [TAG_W-1:0]   cdb_tag [CDB_W];
  logic [DATA_W-1:0]  cdb_val [CDB_W];

  modport master (
    output src_valid, src_tag, src_val,
    input  src_ready, cdb_valid, cdb_tag, cdb_val
  );

  modport slave (
    input  src_valid, src_tag, src_val,
    output src_ready, cdb_valid, cdb_tag, cdb_val
  );
endinterface

// File: rtl/cdb_broadcast.sv
// Per-source result FIFOs drained onto CDB_W registered lanes by rotating priority; push-to-lane latency 2 cycles.
// A source is held off only while its own FIFO is full; the CDB side has no backpressure.
module cdb_broadcast #(
  parameter global_config_pkg::cfg_t Cfg = global_config_pkg::Cfg,
  parameter int NUM_SRC    = 4,
  parameter int CDB_W      = 4,
  parameter int DATA_W     = Cfg.ILEN,
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  cdb_broadcast_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LANE_W = (CDB_W > 1) ? $clog2(CDB_W) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [RR_W-1:0]  LAST_IDX = RR_W'(NUM_SRC - 1);

  if (CDB_W > NUM_SRC) begin : g_bad_lanes
    $error("cdb_broadcast: CDB_W must not exceed NUM_SRC");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cdb_broadcast: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } ent_t;

  ent_t             mem_q    [NUM_SRC][FIFO_DEPTH];
  ent_t             mem_d    [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_d [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_d [NUM_SRC];
  logic [CNT_W-1:0] cnt_q    [NUM_SRC];
  logic [CNT_W-1:0] cnt_d    [NUM_SRC];
  logic [RR_W-1:0]  rr_q, rr_d;
  logic [CDB_W-1:0] lane_vld_q, lane_vld_d;
  ent_t             lane_q   [CDB_W];
  ent_t             lane_d   [CDB_W];

  logic [NUM_SRC-1:0] ready, cand, push, grant, pop;
  ent_t               head     [NUM_SRC];
  logic [RR_W-1:0]    lane_src [CDB_W];
  logic [CDB_W-1:0]   lane_hit;
  logic [RR_W-1:0]    last_src;

  // Ready and candidacy both look only at the start-of-cycle count: no bypass, no same-cycle slot reuse.
  always_comb begin
    ready = '0;
    cand  = '0;
    push  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ready[i] = !rst && !flush && (cnt_q[i] != FULL_CNT);
      cand[i]  = (cnt_q[i] != '0);
      push[i]  = bus.src_valid[i] && ready[i];
      head[i]  = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign bus.src_ready = ready;

  always_comb begin
    int n;
    int s;
    grant    = '0;
    lane_hit = '0;
    last_src = rr_q;
    n        = 0;
    s        = 0;
    for (int k = 0; k < CDB_W; k++) begin
      lane_src[k] = '0;
    end
    // Circular scan from rr_q; the k-th non-empty source found lands on lane k.
    for (int j = 0; j < NUM_SRC; j++) begin
      s = int'(rr_q) + j;
      if (s >= NUM_SRC) begin
        s = s - NUM_SRC;
      end
      if (cand[RR_W'(s)] && (n < CDB_W)) begin
        grant[RR_W'(s)]       = 1'b1;
        lane_src[LANE_W'(n)]  = RR_W'(s);
        lane_hit[LANE_W'(n)]  = 1'b1;
        last_src              = RR_W'(s);
        n                     = n + 1;
      end
    end
    pop = grant & {NUM_SRC{!rst && !flush}};
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        mem_d[i][d] = mem_q[i][d];
      end
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = '{tag: bus.src_tag[i], val: bus.src_val[i]};
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (flush) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end
    end

    rr_d = rr_q;
    if (flush) begin
      rr_d = '0;
    end else if (|grant) begin
      rr_d = (last_src == LAST_IDX) ? '0 : last_src + RR_W'(1);
    end

    // Flush kills lane valids but leaves the last tag/value on the wires.
    for (int k = 0; k < CDB_W; k++) begin
      lane_vld_d[k] = lane_hit[k] && !flush;
      lane_d[k]     = lane_hit[k] ? head[lane_src[k]] : '0;
      if (flush) begin
        lane_d[k] = lane_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q       <= '0;
      lane_vld_q <= '0;
      for (int k = 0; k < CDB_W; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_q       <= rr_d;
      lane_vld_q <= lane_vld_d;
      for (int k = 0; k < CDB_W; k++) begin
        lane_q[k] <= lane_d[k];
      end
    end
  end

  // Storage needs no reset: an entry is only read after the count says it was written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        mem_q[i][d] <= mem_d[i][d];
      end
    end
  end

  assign bus.cdb_valid = lane_vld_q;

  always_comb begin
    for (int k = 0; k < CDB_W; k++) begin
      bus.cdb_tag[k] = lane_q[k].tag;
      bus.cdb_val[k] = lane_q[k].val;
    end
  end
endmodule
